// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, operation
// payload, ALU function-select codes, flag bit positions and a one-hot helper.
package alu_arb_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FS_W    = 5;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned MAX_REQ = 4;

  // Flag vector layout {Z,C,N,O}
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_O = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESPOND = 2'd3
  } arb_state_e;

  // One requester's operation as presented to the ALU
  typedef struct packed {
    logic [FS_W-1:0]   fun_sel;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              wf;
  } alu_op_t;

  // ALU function selects: 16-bit group (MSB 0) and 32-bit group (MSB 1)
  localparam logic [FS_W-1:0] FS_A16    = 5'b00000;
  localparam logic [FS_W-1:0] FS_B16    = 5'b00001;
  localparam logic [FS_W-1:0] FS_NOTA16 = 5'b00010;
  localparam logic [FS_W-1:0] FS_NOTB16 = 5'b00011;
  localparam logic [FS_W-1:0] FS_ADD16  = 5'b00100;
  localparam logic [FS_W-1:0] FS_ADC16  = 5'b00101;
  localparam logic [FS_W-1:0] FS_SUB16  = 5'b00110;
  localparam logic [FS_W-1:0] FS_AND16  = 5'b00111;
  localparam logic [FS_W-1:0] FS_OR16   = 5'b01000;
  localparam logic [FS_W-1:0] FS_XOR16  = 5'b01001;
  localparam logic [FS_W-1:0] FS_NAND16 = 5'b01010;
  localparam logic [FS_W-1:0] FS_LSL16  = 5'b01011;
  localparam logic [FS_W-1:0] FS_LSR16  = 5'b01100;
  localparam logic [FS_W-1:0] FS_ASR16  = 5'b01101;
  localparam logic [FS_W-1:0] FS_CSL16  = 5'b01110;
  localparam logic [FS_W-1:0] FS_CSR16  = 5'b01111;
  localparam logic [FS_W-1:0] FS_A32    = 5'b10000;
  localparam logic [FS_W-1:0] FS_B32    = 5'b10001;
  localparam logic [FS_W-1:0] FS_NOTA32 = 5'b10010;
  localparam logic [FS_W-1:0] FS_NOTB32 = 5'b10011;
  localparam logic [FS_W-1:0] FS_ADD32  = 5'b10100;
  localparam logic [FS_W-1:0] FS_ADC32  = 5'b10101;
  localparam logic [FS_W-1:0] FS_SUB32  = 5'b10110;
  localparam logic [FS_W-1:0] FS_AND32  = 5'b10111;
  localparam logic [FS_W-1:0] FS_OR32   = 5'b11000;
  localparam logic [FS_W-1:0] FS_XOR32  = 5'b11001;
  localparam logic [FS_W-1:0] FS_NAND32 = 5'b11010;
  localparam logic [FS_W-1:0] FS_LSL32  = 5'b11011;
  localparam logic [FS_W-1:0] FS_LSR32  = 5'b11100;
  localparam logic [FS_W-1:0] FS_ASR32  = 5'b11101;
  localparam logic [FS_W-1:0] FS_CSL32  = 5'b11110;
  localparam logic [FS_W-1:0] FS_CSR32  = 5'b11111;

  function automatic logic [MAX_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    id_onehot = MAX_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Ports: req (request vector), last (previous winner) -> valid_c, idx_c
// (first requester found searching upward from last+1, wrapping at NREQ).
module rr_pick
  import alu_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last,
  output logic            valid_c,
  output logic [ID_W-1:0] idx_c
);

  logic [MAX_REQ-1:0] req_pad;
  logic [ID_W-1:0]    cand;

  assign req_pad = MAX_REQ'(req);

  // Walk NREQ candidates starting after last; the first hit wins
  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    cand    = last;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (cand == ID_W'(NREQ - 1)) ? '0 : cand + ID_W'(1);
      if (!valid_c && req_pad[cand]) begin
        valid_c = 1'b1;
        idx_c   = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU among NREQ requesters.
// Sequence per operation: IDLE (grant) -> ISSUE -> CAPTURE -> RESPOND (Ack).
// Ports: Clock, Reset (sync, active-high); Req/ReqFunSel/ReqA/ReqB/ReqWF
// packed per requester; ALU_FunSel/ALU_A/ALU_B/ALU_WF to the ALU,
// ALU_Out/ALU_Flags back; Result/ResultFlags/Ack/GrantId/Busy to requesters.
// Optional feature macro ALU_ARB_LOCK_EN adds ReqLock, which keeps the grant
// with the current winner for its next operation.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NREQ-1:0]        Req,
  input  logic [FS_W*NREQ-1:0]   ReqFunSel,
  input  logic [DATA_W*NREQ-1:0] ReqA,
  input  logic [DATA_W*NREQ-1:0] ReqB,
  input  logic [NREQ-1:0]        ReqWF,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]        ReqLock,
`endif
  output logic [FS_W-1:0]        ALU_FunSel,
  output logic [DATA_W-1:0]      ALU_A,
  output logic [DATA_W-1:0]      ALU_B,
  output logic                   ALU_WF,
  input  logic [DATA_W-1:0]      ALU_Out,
  input  logic [FLAG_W-1:0]      ALU_Flags,
  output logic [DATA_W-1:0]      Result,
  output logic [FLAG_W-1:0]      ResultFlags,
  output logic [NREQ-1:0]        Ack,
  output logic [ID_W-1:0]        GrantId,
  output logic                   Busy
);

  arb_state_e        state_q, state_d;
  alu_op_t           op_q, op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   req_eff_c;
  logic              win_valid_c;
  logic [ID_W-1:0]   win_idx_c;
  alu_op_t           req_op [MAX_REQ];

  // Unpack each requester's operation; unused slots read as zero
  for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_op
    if (gi < NREQ) begin : g_live
      assign req_op[gi] = '{fun_sel: ReqFunSel[FS_W*gi +: FS_W],
                            a:       ReqA[DATA_W*gi +: DATA_W],
                            b:       ReqB[DATA_W*gi +: DATA_W],
                            wf:      ReqWF[gi]};
    end else begin : g_pad
      assign req_op[gi] = '0;
    end
  end

`ifdef ALU_ARB_LOCK_EN
  logic               lock_q, lock_d;
  logic [MAX_REQ-1:0] lock_pad;

  assign lock_pad = MAX_REQ'(ReqLock);
  // While locked only the holder of the lock may be granted
  assign req_eff_c = lock_q ? (Req & NREQ'(id_onehot(grant_q))) : Req;
`else
  assign req_eff_c = Req;
`endif

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req     (req_eff_c),
    .last    (last_q),
    .valid_c (win_valid_c),
    .idx_c   (win_idx_c)
  );

  // State and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      ack_q    <= '0;
      grant_q  <= '0;
      last_q   <= ID_W'(NREQ - 1);
      busy_q   <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
      lock_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      ack_q    <= ack_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
`ifdef ALU_ARB_LOCK_EN
      lock_q   <= lock_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    ack_d    = '0;
    grant_d  = grant_q;
    last_d   = last_q;
`ifdef ALU_ARB_LOCK_EN
    lock_d   = lock_q;
`endif
    unique case (state_q)
      IDLE: begin
        op_d.wf = 1'b0;
        if (win_valid_c) begin
          op_d    = req_op[win_idx_c];
          grant_d = win_idx_c;
`ifdef ALU_ARB_LOCK_EN
          lock_d  = lock_pad[win_idx_c];
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // ALU consumes the operation at this edge; keep flags safe afterwards
        op_d.wf = 1'b0;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        result_d = ALU_Out;
        flags_d  = ALU_Flags;
        ack_d    = NREQ'(id_onehot(grant_q));
        last_d   = grant_q;
        state_d  = RESPOND;
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign ALU_FunSel  = op_q.fun_sel;
  assign ALU_A       = op_q.a;
  assign ALU_B       = op_q.b;
  assign ALU_WF      = op_q.wf;
  assign Result      = result_q;
  assign ResultFlags = flags_q;
  assign Ack         = ack_q;
  assign GrantId     = grant_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with NREQ=2 and a behavioural ALU
// (registered result, flags written only when WF is high).
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int unsigned N = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [5*N-1:0]    req_fs;
  logic [32*N-1:0]   req_a;
  logic [32*N-1:0]   req_b;
  logic [N-1:0]      req_wf;
  logic [N-1:0]      req_lock;
  logic [4:0]        alu_fs;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic              alu_wf;
  logic [31:0]       alu_out = '0;
  logic [3:0]        alu_flags = '0;
  logic [31:0]       result;
  logic [3:0]        result_flags;
  logic [N-1:0]      ack;
  logic [1:0]        grant_id;
  logic              busy;

  alu_arbiter #(.NREQ(N)) dut (
    .Clock       (clk),
    .Reset       (rst),
    .Req         (req),
    .ReqFunSel   (req_fs),
    .ReqA        (req_a),
    .ReqB        (req_b),
    .ReqWF       (req_wf),
`ifdef ALU_ARB_LOCK_EN
    .ReqLock     (req_lock),
`endif
    .ALU_FunSel  (alu_fs),
    .ALU_A       (alu_a),
    .ALU_B       (alu_b),
    .ALU_WF      (alu_wf),
    .ALU_Out     (alu_out),
    .ALU_Flags   (alu_flags),
    .Result      (result),
    .ResultFlags (result_flags),
    .Ack         (ack),
    .GrantId     (grant_id),
    .Busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference ALU arithmetic for the operations the bench uses
  function automatic void alu_calc(input logic [4:0] fs, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] fin,
                                   output logic [31:0] res, output logic [3:0] fout);
    logic [32:0] s;
    fout = fin;
    res  = a;
    s    = '0;
    case (fs)
      FS_ADD32, FS_ADC32: begin
        s = {1'b0, a} + {1'b0, b} + ((fs == FS_ADC32) ? 33'(fin[FLAG_C]) : 33'd0);
        res = s[31:0];
        fout[FLAG_C] = s[32];
        fout[FLAG_O] = (a[31] == b[31]) && (res[31] != a[31]);
      end
      FS_SUB32: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        res = s[31:0];
        fout[FLAG_C] = s[32];
        fout[FLAG_O] = (a[31] != b[31]) && (res[31] != a[31]);
      end
      FS_AND32: res = a & b;
      FS_XOR32: res = a ^ b;
      default:  res = a;
    endcase
    fout[FLAG_Z] = (res == 32'd0);
    fout[FLAG_N] = res[31];
  endfunction

  // Behavioural ALU: evaluates every cycle, writes flags only with WF
  always @(posedge clk) begin : alu_model
    logic [31:0] r;
    logic [3:0]  f;
    alu_calc(alu_fs, alu_a, alu_b, alu_flags, r, f);
    alu_out <= r;
    if (alu_wf) alu_flags <= f;
  end

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   order_q[$];
  logic [3:0] pf = '0;   // predicted ALU flag register
  bit   gap_on = 1'b0;
  int   prev_ack = -1;

  task automatic drive_req(input int i, input logic [4:0] fs, input logic [31:0] a,
                           input logic [31:0] b, input logic wf, input logic lk);
    req_fs[5*i +: 5]  = fs;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_wf[i]   = wf;
    req_lock[i] = lk;
    req[i]      = 1'b1;
  endtask

  task automatic start_op(input int i, input logic [4:0] fs, input logic [31:0] a,
                          input logic [31:0] b, input logic wf, input logic lk);
    exp_t e;
    logic [31:0] r;
    logic [3:0]  f;
    alu_calc(fs, a, b, pf, r, f);
    e.res = r;
    e.flg = wf ? f : pf;
    if (wf) pf = f;
    if (i == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    drive_req(i, fs, a, b, wf, lk);
  endtask

  task automatic wait_ack(input int i);
    bit got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (ack[i]) got = 1'b1;
    end
    if (!got) check($sformatf("ack_timeout_r%0d", i), 64'd0, 64'd1);
    @(posedge clk);
    #1;
    req[i]      = 1'b0;
    req_lock[i] = 1'b0;
  endtask

  task automatic issue(input int i, input logic [4:0] fs, input logic [31:0] a,
                       input logic [31:0] b, input logic wf, input logic lk);
    @(negedge clk);
    start_op(i, fs, a, b, wf, lk);
    wait_ack(i);
  endtask

  task automatic score(input int i);
    exp_t e;
    bit   have;
    have = (i == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
    if (!have) begin
      check($sformatf("unexpected_ack_r%0d", i), 64'(ack), 64'd0);
    end else begin
      e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check($sformatf("result_r%0d", i), 64'(result), 64'(e.res));
      check($sformatf("flags_r%0d", i), 64'(result_flags), 64'(e.flg));
      check($sformatf("grant_at_ack_r%0d", i), 64'(grant_id), 64'(i));
    end
  endtask

  // Scoreboard monitor: compare on every Ack, away from the active edge
  always @(negedge clk) begin
    if (ack != '0) begin
      check("ack_onehot", 64'($onehot(ack)), 64'd1);
      if (ack[0]) score(0);
      if (ack[1]) score(1);
      if (order_q.size() != 0) check("grant_order", 64'(grant_id), 64'(order_q.pop_front()));
      if (gap_on && prev_ack >= 0) check("ack_spacing", 64'(cyc - prev_ack), 64'd4);
      prev_ack = cyc;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_result"}, 64'(result), 64'd0);
    check({tag, "_flags"}, 64'(result_flags), 64'd0);
    check({tag, "_ack"}, 64'(ack), 64'd0);
    check({tag, "_grant"}, 64'(grant_id), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_alu_fs"}, 64'(alu_fs), 64'd0);
    check({tag, "_alu_a"}, 64'(alu_a), 64'd0);
    check({tag, "_alu_b"}, 64'(alu_b), 64'd0);
    check({tag, "_alu_wf"}, 64'(alu_wf), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; req_fs = '0; req_a = '0; req_b = '0;
    req_wf = '0; req_lock = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Single ADD32 with cycle-by-cycle checks
    start_op(0, FS_ADD32, 32'd5, 32'd7, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("t1_issue_busy", 64'(busy), 64'd1);
    check("t1_issue_wf", 64'(alu_wf), 64'd1);
    check("t1_issue_fs", 64'(alu_fs), 64'(FS_ADD32));
    check("t1_issue_a", 64'(alu_a), 64'd5);
    check("t1_issue_ack", 64'(ack), 64'd0);
    @(negedge clk);
    check("t1_capture_wf", 64'(alu_wf), 64'd0);
    check("t1_capture_busy", 64'(busy), 64'd1);
    check("t1_capture_ack", 64'(ack), 64'd0);
    @(negedge clk);
    check("t1_respond_ack", 64'(ack), 64'd1);
    check("t1_result", 64'(result), 64'd12);
    check("t1_flags", 64'(result_flags), 64'd0);
    check("t1_respond_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(negedge clk);
    check("t1_idle_busy", 64'(busy), 64'd0);
    check("t1_idle_ack", 64'(ack), 64'd0);
    check("t1_result_hold", 64'(result), 64'd12);

    // SUB to zero sets Z; a following WF=0 op leaves Z alone
    issue(1, FS_SUB32, 32'h1234, 32'h1234, 1'b1, 1'b0);
    check("t2_sub_result", 64'(result), 64'd0);
    check("t2_sub_z", 64'(result_flags[FLAG_Z]), 64'd1);
    issue(0, FS_AND32, 32'hF0F0, 32'h0FF0, 1'b0, 1'b0);
    check("t3_and_result", 64'(result), 64'h00F0);
    check("t3_z_kept", 64'(result_flags[FLAG_Z]), 64'd1);

    // Continuous requests from both: alternate, one Ack every 4 cycles
    order_q = '{1, 0, 1, 0, 1, 0};
    gap_on = 1'b1; prev_ack = -1;
    fork
      for (int k = 0; k < 3; k++) issue(0, FS_ADD32, 32'(k * 3 + 1), 32'd100, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) issue(1, FS_XOR32, 32'hA5A5_0000 + 32'(k), 32'hFFFF, 1'b0, 1'b0);
    join
    gap_on = 1'b0;

    // Carry chain from requester 0 while requester 1 competes
`ifdef ALU_ARB_LOCK_EN
    order_q = '{0, 0, 1};
`else
    order_q = '{0, 1, 0};
`endif
    gap_on = 1'b1; prev_ack = -1;
    fork
      begin
        issue(0, FS_ADD32, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1);
        issue(0, FS_ADC32, 32'd0, 32'd0, 1'b0, 1'b0);
      end
      begin
        repeat (2) @(negedge clk);
        issue(1, FS_AND32, 32'h1234_5678, 32'hFF, 1'b0, 1'b0);
      end
    join
    gap_on = 1'b0;

    // Reset during CAPTURE abandons the operation
    @(negedge clk);
    drive_req(0, FS_ADD32, 32'd10, 32'd20, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);
    check("post_reset_no_ack", 64'(ack), 64'd0);

    // After reset requester 0 wins first
    order_q = '{0, 1};
    gap_on = 1'b1; prev_ack = -1;
    fork
      issue(0, FS_ADD32, 32'd40, 32'd2, 1'b1, 1'b0);
      issue(1, FS_SUB32, 32'd3, 32'd5, 1'b1, 1'b0);
    join
    gap_on = 1'b0;

    // Request dropped and operands changed during ISSUE
    @(negedge clk);
    start_op(1, FS_ADD32, 32'd100, 32'd23, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    req_a[63:32] = 32'd999;
    req_fs[9:5] = FS_SUB32;
    wait_ack(1);
    check("t7_result", 64'(result), 64'd123);

    repeat (2) @(negedge clk);
    check("end_q0_empty", 64'(exp_q0.size()), 64'd0);
    check("end_q1_empty", 64'(exp_q1.size()), 64'd0);
    check("end_order_empty", 64'(order_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
